// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply, restoring divide.
// Define MULDIV_SIGNED_EN to make op 00/10 signed; otherwise every op runs unsigned.
module mul_div_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operandA,
   input  logic [DATA_WIDTH-1:0] operandB,
   input  logic                  hiWrite,
   input  logic                  loWrite,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic                  busy,
   output logic                  done,
   output logic                  divByZero,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);
   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
   logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
   logic            dbz_q, dbz_d;

   logic            accept, last_iter;
   logic [W-1:0]    mag_a, mag_b;
   logic [W:0]      mul_sum;
   logic [2*W-1:0]  prod_raw, prod_res;
   logic [W:0]      div_shift;
   logic            div_ge;
   logic [W-1:0]    div_diff, quo_raw, rem_raw, quo_res, rem_res;

   assign accept    = start & ((state_q == StIdle) | (state_q == StDone));
   assign last_iter = (cnt_q == CntW'(W - 1));

   // Multiply: acc holds the running upper half, sh shifts the multiplier out as product bits enter.
   assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
   assign prod_raw = {mul_sum, sh_q[W-1:1]};

   // Divide: acc is the partial remainder, sh shifts dividend bits out and quotient bits in.
   assign div_shift = {acc_q, sh_q[W-1]};
   assign div_ge    = (div_shift >= {1'b0, opb_q});
   assign div_diff  = div_shift[W-1:0] - opb_q;
   assign quo_raw   = {sh_q[W-2:0], div_ge};
   assign rem_raw   = div_ge ? div_diff : div_shift[W-1:0];

`ifdef MULDIV_SIGNED_EN
   logic sgn_a, sgn_b, res_neg_q, rem_neg_q;

   assign sgn_a = ~op[0] & operandA[W-1];
   assign sgn_b = ~op[0] & operandB[W-1];
   assign mag_a = sgn_a ? -operandA : operandA;
   assign mag_b = sgn_b ? -operandB : operandB;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else if (accept) begin
         res_neg_q <= sgn_a ^ sgn_b;
         rem_neg_q <= sgn_a;
      end
   end

   assign prod_res = res_neg_q ? -prod_raw : prod_raw;
   assign quo_res  = res_neg_q ? -quo_raw : quo_raw;
   assign rem_res  = rem_neg_q ? -rem_raw : rem_raw;
`else
   logic unused_op0;

   assign unused_op0 = op[0];
   assign mag_a      = operandA;
   assign mag_b      = operandB;
   assign prod_res   = prod_raw;
   assign quo_res    = quo_raw;
   assign rem_res    = rem_raw;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      case (state_q)
         StMul: begin
            acc_d = mul_sum[W:1];
            sh_d  = {mul_sum[0], sh_q[W-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               hi_d    = prod_res[2*W-1:W];
               lo_d    = prod_res[W-1:0];
               state_d = StDone;
            end
         end
         StDiv: begin
            if (dbz_q) begin
               state_d = StDone;
            end else begin
               acc_d = rem_raw;
               sh_d  = quo_raw;
               cnt_d = cnt_q + 1'b1;
               if (last_iter) begin
                  hi_d    = rem_res;
                  lo_d    = quo_res;
                  state_d = StDone;
               end
            end
         end
         default: begin
            // Idle and Done both accept register writes and a new operation.
            state_d = StIdle;
            if (hiWrite) hi_d = writeData;
            if (loWrite) lo_d = writeData;
            if (accept) begin
               state_d = op[1] ? StDiv : StMul;
               cnt_d   = '0;
               acc_d   = '0;
               sh_d    = mag_a;
               opb_d   = mag_b;
               dbz_d   = op[1] & ~|operandB;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy      = (state_q == StMul) | (state_q == StDiv);
   assign done      = (state_q == StDone);
   assign divByZero = dbz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level arithmetic model plus directed vectors.
// Expectations follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_mul_div_unit;
   localparam int W = 32;

   logic          clk, rst, start, hiWrite, loWrite;
   logic [1:0]    op;
   logic [W-1:0]  operandA, operandB, writeData;
   logic          busy, done, divByZero;
   logic [W-1:0]  hi, lo;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_on = 1'b0;

   // Model state
   int           m_left = 0;
   logic         m_done = 1'b0, m_dbz = 1'b0, e_dbz = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0, e_hi = '0, e_lo = '0;

   mul_div_unit #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operandA(operandA), .operandB(operandB),
      .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
      .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] rh, output logic [W-1:0] rl);
      logic               sgn;
      logic signed [63:0] sa, sb;
      logic [63:0]        p;
      sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn = ~o[0];
`endif
      sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      rh = '0;
      rl = '0;
      if (!o[1]) begin
         p  = sa * sb;
         rh = p[63:32];
         rl = p[31:0];
      end else if (b != 0) begin
         p  = sa / sb;
         rl = p[31:0];
         p  = sa % sb;
         rh = p[31:0];
      end
   endtask

   // Model: advances on each rising edge, clears immediately on reset.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               if (!e_dbz) begin
                  m_hi = e_hi;
                  m_lo = e_lo;
               end
            end
         end else begin
            m_done = 1'b0;
            if (hiWrite) m_hi = writeData;
            if (loWrite) m_lo = writeData;
            if (start) begin
               model_op(op, operandA, operandB, e_hi, e_lo);
               e_dbz  = op[1] && (operandB == 0);
               m_dbz  = e_dbz;
               m_left = e_dbz ? 1 : W;
            end
         end
      end
   end

   // Compare every cycle on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            check("cyc_busy", busy, m_left > 0);
            check("cyc_done", done, m_done);
            check("cyc_dbz", divByZero, m_dbz);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
         end
      end
   end

   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = busy ? 1 : 0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         if (busy) nbusy++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", lat);
      end
   endtask

   // Called on a falling edge; returns on the falling edge where done is high.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int nbusy);
      start = 1'b1; op = o; operandA = a; operandB = b;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nbusy);
   endtask

   int lat, nb, ndone;

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
      hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
      #2 rst = 1'b0;
      chk_on = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_hi", hi, 0);
      check("reset_busy", {busy, done, divByZero}, 3'b000);
      rst = 1'b1;
      @(negedge clk);

      // 1: MULTU max * max
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb);
      check("t1_latency", lat, 33);
      check("t1_busy_cycles", nb, 32);
      check("t1_hi", hi, 32'hFFFF_FFFE);
      check("t1_lo", lo, 32'h0000_0001);
      check("t1_model_hi", m_hi, 32'hFFFF_FFFE);

      // 2: DIVU 100/7, started straight from the done cycle
      run_op(2'b11, 32'd100, 32'd7, lat, nb);
      check("t2_latency", lat, 33);
      check("t2_lo", lo, 32'd14);
      check("t2_hi", hi, 32'd2);
      check("t2_dbz", divByZero, 0);
      check("t2_model_lo", m_lo, 32'd14);

      // 3: MTHI then DIVU by zero
      @(negedge clk);
      hiWrite = 1'b1; writeData = 32'hAAAA_0000;
      @(negedge clk);
      hiWrite = 1'b0;
      check("t3_mthi", hi, 32'hAAAA_0000);
      run_op(2'b11, 32'd5, 32'd0, lat, nb);
      check("t3_latency", lat, 2);
      check("t3_dbz", divByZero, 1);
      check("t3_hi_kept", hi, 32'hAAAA_0000);
      check("t3_lo_kept", lo, 32'd14);
      @(negedge clk);
      check("t3_dbz_holds", divByZero, 1);

      // 4: MTHI on the accept edge, then ignored start/MTLO while busy
      hiWrite = 1'b1; writeData = 32'hDEAD_BEEF;
      start = 1'b1; op = 2'b01; operandA = 32'd3; operandB = 32'd5;
      @(negedge clk);
      start = 1'b0; hiWrite = 1'b0;
      check("t4_hi_written", hi, 32'hDEAD_BEEF);
      check("t4_dbz_cleared", divByZero, 0);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'b11; operandA = 32'd9; operandB = 32'd3;
      loWrite = 1'b1; writeData = 32'h0000_1234;
      @(negedge clk);
      start = 1'b0; loWrite = 1'b0;
      wait_done(lat, nb);
      check("t4_hi", hi, 32'd0);
      check("t4_lo", lo, 32'd15);
      loWrite = 1'b1; writeData = 32'h1234_5678;
      @(negedge clk);
      loWrite = 1'b0;
      check("t4_mtlo", lo, 32'h1234_5678);
      repeat (3) @(negedge clk);
      check("t4_not_queued", {busy, done}, 2'b00);

      // 6: signed/unsigned interpretation of op 00/10
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, nb);
`ifdef MULDIV_SIGNED_EN
      check("t6_mult_hi", hi, 32'hFFFF_FFFF);
`else
      check("t6_mult_hi", hi, 32'h0000_0004);
`endif
      check("t6_mult_lo", lo, 32'hFFFF_FFF1);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb);
`ifdef MULDIV_SIGNED_EN
      check("t6_div_lo", lo, 32'hFFFF_FFFD);
      check("t6_div_hi", hi, 32'hFFFF_FFFF);
`else
      check("t6_div_lo", lo, 32'h7FFF_FFFC);
      check("t6_div_hi", hi, 32'h0000_0001);
`endif
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
`ifdef MULDIV_SIGNED_EN
      check("t6_min_lo", lo, 32'h8000_0000);
      check("t6_min_hi", hi, 32'h0000_0000);
`else
      check("t6_min_lo", lo, 32'h0000_0000);
      check("t6_min_hi", hi, 32'h8000_0000);
`endif
      check("t6_min_latency", lat, 33);

      // 5: asynchronous reset mid-multiply
      run_op(2'b01, 32'h1234_5678, 32'd9, lat, nb);
      start = 1'b1; op = 2'b01; operandA = 32'h0F0F_0F0F; operandB = 32'd77;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_hi", hi, 0);
      check("t5_lo", lo, 0);
      @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("t5_no_done", ndone, 0);
      check("t5_lo_still0", lo, 0);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
